// File: rtl/vlsu_cam_alloc_ctrl_if.sv
// Bundled allocation, retire, lookup, response and CAM-side signals of vlsu_cam_alloc_ctrl.
// The slave modport is the controller's view; master is the requester/CAM side.
interface vlsu_cam_alloc_ctrl_if #(
  parameter int WIDTH   = 50,
  parameter int DEPTH   = 32,
  parameter int READ    = 3,
  parameter int ADDRESS = $clog2(DEPTH)
);

  logic                              alloc_valid_i;
  logic [WIDTH-1:0]                  alloc_data_i;
  logic                              alloc_ready_o;
  logic [ADDRESS-1:0]                alloc_addr_o;
  logic                              retire_i;
  logic                              flush_i;
  logic [READ-1:0]                   lookup_valid_i;
  logic [READ-1:0][WIDTH-1:0]        lookup_data_i;
  logic [READ-1:0]                   rsp_valid_o;
  logic [READ-1:0]                   rsp_hit_o;
  logic [READ-1:0][ADDRESS-1:0]      rsp_addr_o;
  logic                              cam_write_o;
  logic [ADDRESS-1:0]                cam_write_addr_o;
  logic [WIDTH-1:0]                  cam_write_data_o;
  logic [ADDRESS-1:0]                cam_head_o;
  logic [READ-1:0][DEPTH-1:0]        cam_enable_o;
  logic [READ-1:0]                   cam_read_o;
  logic [READ-1:0][WIDTH-1:0]        cam_read_data_o;
  logic [READ-1:0]                   cam_match_i;
  logic [READ-1:0][ADDRESS-1:0]      cam_match_addr_i;
  logic [ADDRESS:0]                  count_o;
  logic                              full_o;
  logic                              empty_o;

  modport slave (
    input  alloc_valid_i, alloc_data_i, retire_i, flush_i,
    input  lookup_valid_i, lookup_data_i, cam_match_i, cam_match_addr_i,
    output alloc_ready_o, alloc_addr_o, rsp_valid_o, rsp_hit_o, rsp_addr_o,
    output cam_write_o, cam_write_addr_o, cam_write_data_o, cam_head_o,
    output cam_enable_o, cam_read_o, cam_read_data_o, count_o, full_o, empty_o
  );

  modport master (
    output alloc_valid_i, alloc_data_i, retire_i, flush_i,
    output lookup_valid_i, lookup_data_i, cam_match_i, cam_match_addr_i,
    input  alloc_ready_o, alloc_addr_o, rsp_valid_o, rsp_hit_o, rsp_addr_o,
    input  cam_write_o, cam_write_addr_o, cam_write_data_o, cam_head_o,
    input  cam_enable_o, cam_read_o, cam_read_data_o, count_o, full_o, empty_o
  );

endinterface

// File: rtl/vlsu_cam_alloc_ctrl.sv
// Circular allocation controller in front of an external CAM: head/tail/count plus valid mask,
// pass-through lookups with 1-cycle registered responses. Define VLSU_CAM_STATS_EN for hit/miss counters.
module vlsu_cam_alloc_ctrl #(
  parameter int WIDTH   = 50,
  parameter int DEPTH   = 32,
  parameter int READ    = 3,
  parameter int ADDRESS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  vlsu_cam_alloc_ctrl_if.slave bus
`ifdef VLSU_CAM_STATS_EN
  ,
  output logic [15:0]          hit_cnt_o,
  output logic [15:0]          miss_cnt_o
`endif
);

  localparam logic [ADDRESS:0]   DEPTH_CNT = (ADDRESS+1)'(DEPTH);
  localparam logic [ADDRESS:0]   ONE_CNT   = {{ADDRESS{1'b0}}, 1'b1};
  localparam logic [ADDRESS-1:0] ONE_PTR   = {{(ADDRESS-1){1'b0}}, 1'b1};

  logic [ADDRESS-1:0] head_q, head_d;
  logic [ADDRESS-1:0] tail_q, tail_d;
  logic [ADDRESS:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [READ-1:0]    rsp_valid_q, rsp_valid_d;

  logic full;
  logic empty;
  logic alloc_fire;
  logic retire_fire;

  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  // Readiness ignores a same-cycle retire so that a full queue never accepts before space is freed.
  assign alloc_fire  = bus.alloc_valid_i && !full && !bus.flush_i;
  assign retire_fire = bus.retire_i && !empty && !bus.flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (bus.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + ONE_PTR;
      end
      if (retire_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + ONE_PTR;
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  // A flush in the lookup cycle kills the response, since the searched entries are gone.
  always_comb begin
    rsp_valid_d = bus.lookup_valid_i & {READ{~bus.flush_i}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.alloc_ready_o    = !full && !bus.flush_i;
  assign bus.alloc_addr_o     = tail_q;
  assign bus.count_o          = count_q;
  assign bus.full_o           = full;
  assign bus.empty_o          = empty;
  assign bus.cam_write_o      = alloc_fire;
  assign bus.cam_write_addr_o = alloc_fire ? tail_q : '0;
  assign bus.cam_write_data_o = alloc_fire ? bus.alloc_data_i : '0;
  assign bus.cam_head_o       = head_q;
  assign bus.cam_read_o       = bus.lookup_valid_i;
  assign bus.cam_read_data_o  = bus.lookup_data_i;
  assign bus.rsp_valid_o      = rsp_valid_q;

  logic [READ-1:0] rsp_hit;
  logic [READ-1:0] rsp_miss;

  // Responses are quiet (hit and address zero) on ports without a pending lookup.
  always_comb begin
    rsp_hit          = '0;
    rsp_miss         = '0;
    bus.rsp_addr_o   = '0;
    bus.cam_enable_o = '0;
    for (int r = 0; r < READ; r++) begin
      rsp_hit[r]          = rsp_valid_q[r] & bus.cam_match_i[r];
      rsp_miss[r]         = rsp_valid_q[r] & ~bus.cam_match_i[r];
      bus.rsp_addr_o[r]   = rsp_valid_q[r] ? bus.cam_match_addr_i[r] : '0;
      bus.cam_enable_o[r] = valid_q;
    end
  end

  assign bus.rsp_hit_o = rsp_hit;

`ifdef VLSU_CAM_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic [16:0] hit_sum;
  logic [16:0] miss_sum;

  // Bit 16 of the running sum flags overflow; at most READ is added per cycle so it cannot wrap.
  always_comb begin
    hit_sum  = {1'b0, hit_cnt_q};
    miss_sum = {1'b0, miss_cnt_q};
    for (int r = 0; r < READ; r++) begin
      hit_sum  = hit_sum + {16'd0, rsp_hit[r]};
      miss_sum = miss_sum + {16'd0, rsp_miss[r]};
    end
    hit_cnt_d  = hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
    miss_cnt_d = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    if (bus.flush_i) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
